// File: rtl/div_pkg.sv
// Shared types and helpers for the multicycle restoring divider.
package div_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;
  localparam int MAX_W     = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Conditional two's-complement negate. The caller zero-extends to MAX_W and truncates
  // the result, so this is exact for any WIDTH up to MAX_W.
  function automatic logic [MAX_W-1:0] fix_sign(input logic [MAX_W-1:0] v, input logic neg);
    return neg ? (~v + MAX_W'(1)) : v;
  endfunction
endpackage

// File: rtl/seq_divider_if.sv
// Request/response bundle between the control unit (master) and the divider (slave).
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  // start is a strobe sampled only while the divider is idle; operands and is_signed are
  // captured on that same edge. The divider answers with exactly one single-cycle pulse:
  // done (quotient/remainder valid) or div_by_zero (request rejected). busy covers the
  // cycles in between; start during busy or during the done cycle is dropped, not queued.
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, div_by_zero, quotient, remainder
  );
endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration on a {rem,quo} register pair.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           fits;
  logic           unused_trial_msb;

  // rem < divisor_mag on entry, so a successful subtraction always fits in WIDTH bits.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, divisor_mag};
    fits     = (shifted >= {1'b0, divisor_mag});
    quo_next = {quo[WIDTH-2:0], fits};
    rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

  assign unused_trial_msb = trial[WIDTH];
endmodule

// File: rtl/seq_divider.sv
// Multicycle radix-2 restoring divider serving DIV/DIVU: quotient to LO, remainder to HI.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  bus,
  output state_t        state_dbg
);
  state_t           state, state_nxt;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem_q, quo_q, dmag_q;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic [WIDTH-1:0] q_out, r_out;
  logic             sgn_q, neg_a_q, neg_b_q, dbz_q;
  logic             busy, done;
  logic             divisor_zero, neg_a_in, neg_b_in;

  assign divisor_zero = (bus.divisor == '0);
  assign neg_a_in     = bus.is_signed & bus.dividend[WIDTH-1];
  assign neg_b_in     = bus.is_signed & bus.divisor[WIDTH-1];

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem         (rem_q),
    .quo         (quo_q),
    .divisor_mag (dmag_q),
    .rem_next    (rem_nxt),
    .quo_next    (quo_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (bus.start && !divisor_zero) state_nxt = CALC;
      CALC: begin
        busy = 1'b1;
        if (count == CNT_W'(1)) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dmag_q  <= '0;
      q_out   <= '0;
      r_out   <= '0;
      sgn_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      dbz_q <= (state == IDLE) && bus.start && divisor_zero;
      case (state)
        IDLE: if (bus.start && !divisor_zero) begin
          sgn_q   <= bus.is_signed;
          neg_a_q <= bus.dividend[WIDTH-1];
          neg_b_q <= bus.divisor[WIDTH-1];
          quo_q   <= WIDTH'(fix_sign(MAX_W'(bus.dividend), neg_a_in));
          dmag_q  <= WIDTH'(fix_sign(MAX_W'(bus.divisor), neg_b_in));
          rem_q   <= '0;
          count   <= CNT_W'(WIDTH);
        end
        CALC: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          count <= count - CNT_W'(1);
        end
        // Remainder follows the dividend's sign; quotient is negative when signs differ.
        FIX: begin
          q_out <= WIDTH'(fix_sign(MAX_W'(quo_q), sgn_q & (neg_a_q ^ neg_b_q)));
          r_out <= WIDTH'(fix_sign(MAX_W'(rem_q), sgn_q & neg_a_q));
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.div_by_zero = dbz_q;
  assign bus.quotient    = q_out;
  assign bus.remainder   = r_out;
  assign state_dbg       = state;
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multicycle radix-2 restoring divider. It is the responder to the control unit's DIV/DIVU request.
- Control unit pulses a start request with operands from the A/B registers. The block iterates, then returns quotient (to the LO mux) and remainder (to the HI mux) with a done pulse.
- It also raises a divide-by-zero flag that the control unit uses for the exception path.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend  input  WIDTH  numerator (A register); sampled with start.
- divisor  input  WIDTH  denominator (B register); sampled with start.
- busy  output  1  high from the cycle after an accepted start until done/div_by_zero.
- done  output  1  one-cycle pulse; results valid.
- div_by_zero  output  1  one-cycle pulse; request rejected.
- quotient  output  WIDTH  to LO mux.
- remainder  output  WIDTH  to HI mux.

Behaviour:
- Reset (reset low, any time, including mid-operation):
  - State goes to IDLE.
  - busy, done, div_by_zero, quotient, remainder all 0.
  - Counter and working registers cleared.
  - No pending request survives reset.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 at edge k:
  - Latch is_signed and the operand signs.
  - Latch |dividend| and |divisor| (magnitudes only when is_signed=1; raw values otherwise).
  - If divisor==0: stay IDLE, div_by_zero=1 for exactly cycle k+1. quotient/remainder keep their previous values. busy stays 0. done is not asserted.
  - Otherwise: go to CALC, counter=WIDTH, busy=1 from cycle k+1.
- CALC (one iteration per edge, WIDTH iterations, edges k+1..k+WIDTH):
  - Shift {rem,quo} left by 1; trial = rem - divisor_mag (WIDTH+1 bits).
  - If trial is non-negative: rem=trial, quo[0]=1; else quo[0]=0.
  - Counter decrements; at counter==1 go to FIX.
- FIX (edge k+WIDTH+1):
  - When is_signed: negate the quotient if the operand signs differ; negate the remainder if the dividend was negative.
  - Write the quotient/remainder output registers; go to DONE.
- DONE (cycle k+WIDTH+2):
  - done=1 for one cycle, busy=0 in the same cycle; return to IDLE.
  - Total latency from start sample to done visible: WIDTH+2 cycles (34 at default).
- Outputs quotient/remainder hold their last valid result until the next FIX; never change during CALC.
- start while busy (CALC/FIX/DONE): ignored, no queueing. Operand inputs may change freely after the start edge.
- start high in the same cycle done is high: that cycle is still in DONE and is ignored; control unit must re-assert start in IDLE.
- Arithmetic rules:
  - Truncation toward zero; remainder takes the dividend's sign (MIPS semantics).
  - Signed -2^31 / -1: quotient 0x80000000, remainder 0; no overflow flag.
  - |x| of 0x80000000 is 0x80000000 treated unsigned.
  - dividend < divisor (unsigned magnitude): quotient 0, remainder = dividend.
- done and div_by_zero are mutually exclusive and never high in consecutive cycles for one request.

Decomposition:
- Package div_pkg:
  - State enum {IDLE, CALC, FIX, DONE}, 2-bit encoding.
  - Default WIDTH/CNT_W constants.
  - Sign-fix helper function (conditional two's-complement negate).
- One sub-module is natural: div_step, combinational single restoring iteration.
  - Inputs: rem, quo, divisor_mag.
  - Outputs: next rem, next quo.
  - Instantiated once inside seq_divider and reusable by a future unrolled variant.

Test Plan:
- Unsigned basic: start, is_signed=0, 7 / 2 -> busy cycles 1..33; done at cycle 34; quotient=0x00000003, remainder=0x00000001.
- Signed negative: is_signed=1, 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
- Divide by zero: 100 / 0 after a prior 7/2 result -> div_by_zero=1 at cycle 1 only, busy never high, done never high, quotient stays 3, remainder stays 1.
- Signed corners, each run as a separate request:
  - 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
  - DIVU 0xFFFFFFFF / 0x10 -> quotient=0x0FFFFFFF, remainder=0xF.
- Busy collision: second start (50/5) pulsed at cycles 5 and 34 of a 7/2 run -> ignored; single done at 34 with 3/1. A new start at cycle 35 yields quotient=10 at cycle 69.
- Reset mid-operation: reset low at cycle 12 of a 1000/3 run -> all outputs 0 immediately (asynchronous). After release, no done appears; a fresh 9/4 completes 34 cycles after its start with quotient=2, remainder=1.
